// File: rtl/alarm_set_controller_pkg.sv
// Purpose: shared types and constants for the alarm front-panel sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package alarm_set_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T_HR   = 3'd1,
        ST_T_MIN  = 3'd2,
        ST_A_HR   = 3'd3,
        ST_A_MIN  = 3'd4,
        ST_SNOOZE = 3'd5
    } state_t;

    // Operation selector for bcd_time_add.
    typedef enum logic [1:0] {
        ADD_HOUR_INC = 2'd0,
        ADD_MIN_INC  = 2'd1,
        ADD_MINUTES  = 2'd2
    } add_mode_t;

    // edit_field codes driven to the display blink logic.
    localparam logic [1:0] FIELD_NONE    = 2'd0;
    localparam logic [1:0] FIELD_HOURS   = 2'd1;
    localparam logic [1:0] FIELD_MINUTES = 2'd2;

    localparam int HOUR_MAX    = 23;
    localparam int MIN_MAX     = 59;
    localparam int MIN_PER_DAY = 1440;

    // hh:mm in BCD, laid out in the same order as the load bus.
    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

    function automatic logic is_edit_state(input state_t s);
        return (s == ST_T_HR) || (s == ST_T_MIN) || (s == ST_A_HR) || (s == ST_A_MIN);
    endfunction

endpackage

// File: rtl/alarm_set_controller_if.sv
// Purpose: panel-side bundle: debounced buttons, current time in, BCD load bus and pulses out.
// Latency: n/a (wires only).
// Backpressure: none; pulses are fire-and-forget single cycles.
interface alarm_set_controller_if;
    import alarm_set_controller_pkg::*;

    logic       btn_mode;
    logic       btn_up;
    logic       btn_cancel;
    logic       btn_snooze;
    logic       alarm_active;
    logic [1:0] cur_hour1;
    logic [3:0] cur_hour0;
    logic [3:0] cur_min1;
    logic [3:0] cur_min0;
    logic [1:0] hour_in1;
    logic [3:0] hour_in0;
    logic [3:0] minute_in1;
    logic [3:0] minute_in0;
    logic       load_time;
    logic       load_alarm;
    logic       stop_alarm;
    logic       editing;
    logic [1:0] edit_field;

    // slave = the sequencer; master = whatever drives the buttons and observes the bus.
    modport slave (
        input  btn_mode, btn_up, btn_cancel, btn_snooze, alarm_active,
        input  cur_hour1, cur_hour0, cur_min1, cur_min0,
        output hour_in1, hour_in0, minute_in1, minute_in0,
        output load_time, load_alarm, stop_alarm, editing, edit_field
    );

    modport master (
        output btn_mode, btn_up, btn_cancel, btn_snooze, alarm_active,
        output cur_hour1, cur_hour0, cur_min1, cur_min0,
        input  hour_in1, hour_in0, minute_in1, minute_in0,
        input  load_time, load_alarm, stop_alarm, editing, edit_field
    );
endinterface

// File: rtl/alarm_set_controller_bcd_time_add.sv
// Purpose: BCD hh:mm adder: hour+1 (wrap 23->00), minute+1 (wrap 59->00, no carry), or +N minutes mod 1440.
// Latency: combinational.
// Backpressure: none.
module bcd_time_add
    import alarm_set_controller_pkg::*;
(
    input  bcd_time_t  time_i,
    input  logic [5:0] addend_i,
    input  add_mode_t  mode_i,
    output bcd_time_t  sum_o
);
    // Everything is done in binary and re-encoded; this gives the 09->10, 19->20
    // and 23->00 hour behaviour without special-casing each BCD digit.
    logic [4:0]  hh_bin;
    logic [5:0]  mm_bin;
    logic [10:0] tot_raw;
    logic [10:0] tot_wrap;
    logic [4:0]  hh_sum;
    logic [5:0]  mm_sum;

    always_comb begin
        hh_bin   = 5'(time_i.h1) * 5'd10 + 5'(time_i.h0);
        mm_bin   = 6'(time_i.m1) * 6'd10 + 6'(time_i.m0);
        tot_raw  = 11'(hh_bin) * 11'd60 + 11'(mm_bin) + 11'(addend_i);
        // addend < 64 so one conditional subtract is enough for the day wrap.
        tot_wrap = (tot_raw >= 11'(MIN_PER_DAY)) ? tot_raw - 11'(MIN_PER_DAY) : tot_raw;
        hh_sum   = hh_bin;
        mm_sum   = mm_bin;
        case (mode_i)
            ADD_HOUR_INC: hh_sum = (hh_bin >= 5'(HOUR_MAX)) ? 5'd0 : hh_bin + 5'd1;
            ADD_MIN_INC:  mm_sum = (mm_bin >= 6'(MIN_MAX)) ? 6'd0 : mm_bin + 6'd1;
            ADD_MINUTES: begin
                hh_sum = 5'(tot_wrap / 11'd60);
                mm_sum = 6'(tot_wrap % 11'd60);
            end
            default: ;
        endcase
        sum_o.h1 = 2'(hh_sum / 5'd10);
        sum_o.h0 = 4'(hh_sum % 5'd10);
        sum_o.m1 = 4'(mm_sum / 6'd10);
        sum_o.m0 = 4'(mm_sum % 6'd10);
    end
endmodule

// File: rtl/alarm_set_controller.sv
// Purpose: front-panel edit FSM for alarm_clock: edits time/alarm via mode/up/cancel, snooze re-arm; ports clk, reset (sync, active-low), panel_if (slave).
// Latency: every output registered; button edge -> output change on the next clk edge.
// Backpressure: none; load_time/load_alarm/stop_alarm are single-cycle, never overlapping.
module alarm_set_controller
    import alarm_set_controller_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int SNOOZE_MIN   = 9
) (
    input  logic                clk,
    input  logic                reset,
    alarm_set_controller_if.slave panel_if
);
    if (SNOOZE_MIN < 1 || SNOOZE_MIN > MIN_MAX) begin : g_bad_snooze
        $error("SNOOZE_MIN must be within 1..59");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = $clog2(RPT_MAX + 1);

    logic        mode_q, up_q, cancel_q, snooze_q;
    logic        mode_edge, up_edge, cancel_edge, snooze_edge;
    state_t      state_q, state_d;
    bcd_time_t   bus_q, bus_d, shadow_q, shadow_d;
    bcd_time_t   cur_time, bus_base, add_in, add_out;
    add_mode_t   add_mode;
    logic        load_time_q, load_time_d, load_alarm_q, load_alarm_d;
    logic        stop_alarm_q, stop_alarm_d;
    logic        editing_q, editing_d;
    logic [1:0]  edit_field_q, edit_field_d;
    logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_on_q, rpt_on_d;
    logic        up_held, rpt_fire, inc;

    assign mode_edge   = panel_if.btn_mode   & ~mode_q;
    assign up_edge     = panel_if.btn_up     & ~up_q;
    assign cancel_edge = panel_if.btn_cancel & ~cancel_q;
    assign snooze_edge = panel_if.btn_snooze & ~snooze_q;

    assign cur_time = {panel_if.cur_hour1, panel_if.cur_hour0, panel_if.cur_min1, panel_if.cur_min0};

    // The cycle carrying load_time still shows the committed time; the alarm
    // shadow takes over the bus from the next edge, and an up edge landing in
    // that cycle is applied on top of the shadow rather than the old time.
    assign bus_base = load_time_q ? shadow_q : bus_q;

    // IDLE only ever needs the snooze sum; edit states need the field increment.
    always_comb begin
        add_in   = bus_base;
        add_mode = ADD_HOUR_INC;
        if (state_q == ST_IDLE) begin
            add_in   = cur_time;
            add_mode = ADD_MINUTES;
        end else if (state_q == ST_T_MIN || state_q == ST_A_MIN) begin
            add_mode = ADD_MIN_INC;
        end
    end

    bcd_time_add u_add (
        .time_i   (add_in),
        .addend_i (6'(SNOOZE_MIN)),
        .mode_i   (add_mode),
        .sum_o    (add_out)
    );

    // Auto-repeat: cnt is the number of held cycles so far; first repeat at
    // REPEAT_DELAY, then every REPEAT_RATE (counter reloads to 1 on each fire).
    assign up_held  = panel_if.btn_up && is_edit_state(state_q);
    assign rpt_fire = up_held && (rpt_on_q ? (rpt_cnt_q == CW'(REPEAT_RATE))
                                           : (rpt_cnt_q == CW'(REPEAT_DELAY)));
    assign inc      = up_edge | rpt_fire;

    always_comb begin
        state_d      = state_q;
        bus_d        = bus_base;
        shadow_d     = shadow_q;
        load_time_d  = 1'b0;
        load_alarm_d = 1'b0;
        stop_alarm_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode_edge) begin
                    state_d = ST_T_HR;
                    bus_d   = cur_time;
                end else if (snooze_edge && panel_if.alarm_active) begin
                    state_d      = ST_SNOOZE;
                    stop_alarm_d = 1'b1;
                    bus_d        = add_out;
                end
            end
            ST_T_HR, ST_A_HR: begin
                if (cancel_edge)    state_d = ST_IDLE;
                else if (mode_edge) state_d = (state_q == ST_T_HR) ? ST_T_MIN : ST_A_MIN;
                else if (inc)       bus_d   = add_out;
            end
            ST_T_MIN: begin
                if (cancel_edge) begin
                    state_d = ST_IDLE;
                end else if (mode_edge) begin
                    state_d     = ST_A_HR;
                    load_time_d = 1'b1;
                end else if (inc) begin
                    bus_d = add_out;
                end
            end
            ST_A_MIN: begin
                if (cancel_edge) begin
                    state_d = ST_IDLE;
                end else if (mode_edge) begin
                    state_d      = ST_IDLE;
                    load_alarm_d = 1'b1;
                    shadow_d     = bus_q;
                end else if (inc) begin
                    bus_d = add_out;
                end
            end
            // Snoozed alarm goes straight to alarm_clock; shadow keeps the user's alarm.
            ST_SNOOZE: begin
                state_d      = ST_IDLE;
                load_alarm_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rpt_cnt_d = '0;
        rpt_on_d  = 1'b0;
        if (up_held && state_d == state_q) begin
            if (rpt_fire) begin
                rpt_cnt_d = CW'(1);
                rpt_on_d  = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + CW'(1);
                rpt_on_d  = rpt_on_q;
            end
        end
    end

    always_comb begin
        editing_d = is_edit_state(state_d);
        case (state_d)
            ST_T_HR, ST_A_HR:   edit_field_d = FIELD_HOURS;
            ST_T_MIN, ST_A_MIN: edit_field_d = FIELD_MINUTES;
            default:            edit_field_d = FIELD_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q       <= 1'b0;
            up_q         <= 1'b0;
            cancel_q     <= 1'b0;
            snooze_q     <= 1'b0;
            state_q      <= ST_IDLE;
            bus_q        <= '0;
            shadow_q     <= '0;
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
            stop_alarm_q <= 1'b0;
            editing_q    <= 1'b0;
            edit_field_q <= FIELD_NONE;
            rpt_cnt_q    <= '0;
            rpt_on_q     <= 1'b0;
        end else begin
            mode_q       <= panel_if.btn_mode;
            up_q         <= panel_if.btn_up;
            cancel_q     <= panel_if.btn_cancel;
            snooze_q     <= panel_if.btn_snooze;
            state_q      <= state_d;
            bus_q        <= bus_d;
            shadow_q     <= shadow_d;
            load_time_q  <= load_time_d;
            load_alarm_q <= load_alarm_d;
            stop_alarm_q <= stop_alarm_d;
            editing_q    <= editing_d;
            edit_field_q <= edit_field_d;
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_on_q     <= rpt_on_d;
        end
    end

    assign panel_if.hour_in1   = bus_q.h1;
    assign panel_if.hour_in0   = bus_q.h0;
    assign panel_if.minute_in1 = bus_q.m1;
    assign panel_if.minute_in0 = bus_q.m0;
    assign panel_if.load_time  = load_time_q;
    assign panel_if.load_alarm = load_alarm_q;
    assign panel_if.stop_alarm = stop_alarm_q;
    assign panel_if.editing    = editing_q;
    assign panel_if.edit_field = edit_field_q;
endmodule
